// File: rtl/aes_key_expand_if.sv
// Round-key generator bus: key-load strobe from the control unit,
// round-key read port and status back to the round datapath.
interface aes_key_expand_if;
    logic         genk;
    logic [127:0] key_in;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         busy;
    logic         keys_ready;

    modport master (
        output genk, key_in, rk_idx,
        input  rk_out, busy, keys_ready
    );

    modport slave (
        input  genk, key_in, rk_idx,
        output rk_out, busy, keys_ready
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry file.
// Build option: define KEYEXP_ZEROIZE_EN to clear rk[1..NR] on every key capture.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = TBL[a];
endmodule

module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             rst,
    aes_key_expand_if.slave  kif
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t                         state;
    logic [NR:0][127:0]             rk;
    logic [127:0]                   cur;
    logic [3:0]                     rnd;
    logic [7:0]                     rcon;
    logic                           busy_q;
    logic                           ready_q;

    logic [NUM_LANES-1:0][VEC_W-1:0] rot_w;
    logic [NUM_LANES-1:0][VEC_W-1:0] sub_w;
    logic [31:0]                    t, n0, n1, n2, n3;
    logic [127:0]                   nxt;
    logic [7:0]                     rcon_nxt;

    // RotWord on w3: byte 0 moves to the least significant position
    assign rot_w = {cur[23:0], cur[31:24]};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aes_sbox u_sbox (.a(rot_w[g]), .y(sub_w[g]));
    end

    assign t        = sub_w ^ {rcon, 24'h0};
    assign n0       = cur[127:96] ^ t;
    assign n1       = cur[95:64]  ^ n0;
    assign n2       = cur[63:32]  ^ n1;
    assign n3       = cur[31:0]   ^ n2;
    assign nxt      = {n0, n1, n2, n3};
    assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rk      <= '0;
            cur     <= '0;
            rnd     <= '0;
            rcon    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (kif.genk) begin
                        rk[0]   <= kif.key_in;
`ifdef KEYEXP_ZEROIZE_EN
                        for (int i = 1; i <= NR; i++) rk[i] <= '0;
`endif
                        cur     <= kif.key_in;
                        rnd     <= 4'd1;
                        rcon    <= 8'h01;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= EXPAND;
                    end
                end
                // genk is deliberately not looked at here: no mid-schedule restart
                EXPAND: begin
                    rk[rnd] <= nxt;
                    cur     <= nxt;
                    rcon    <= rcon_nxt;
                    rnd     <= rnd + 4'd1;
                    if (rnd == LAST) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kif.rk_out     = (kif.rk_idx <= LAST) ? rk[kif.rk_idx] : '0;
    assign kif.busy       = busy_q;
    assign kif.keys_ready = ready_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues expected read results,
// a monitor samples rk_out/busy/keys_ready and compares.
module tb_aes_key_expand;
    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        string        name;
        logic [127:0] rk;
        logic         busy;
        logic         kr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rd_req;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    aes_key_expand_if kif ();

    aes_key_expand #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] idx, input logic [127:0] r,
                       input logic b, input logic k);
        exp_t e;
        kif.rk_idx = idx;
        e.name = nm; e.rk = r; e.busy = b; e.kr = k;
        sb.push_back(e);
        rd_req = ~rd_req;
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(rd_req);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL orphan_read: got rk=%h with no expectation queued", kif.rk_out);
            end else begin
                e = sb.pop_front();
                if (kif.rk_out !== e.rk || kif.busy !== e.busy || kif.keys_ready !== e.kr) begin
                    bad++;
                    $display("FAIL %s: got rk=%h busy=%b kr=%b, want rk=%h busy=%b kr=%b",
                             e.name, kif.rk_out, kif.busy, kif.keys_ready, e.rk, e.busy, e.kr);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; rd_req = 1'b0;
        kif.genk = 1'b0; kif.key_in = '0; kif.rk_idx = '0;
        repeat (2) @(negedge clk);
        chk("rst_rk0", 4'd0, '0, 1'b0, 1'b0);
        chk("rst_rk10", 4'd10, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_quiet", 4'd0, '0, 1'b0, 1'b0);

        // FIPS-197 key, with an ignored genk sampled at E0+4
        kif.key_in = K1; kif.genk = 1'b1;
        @(negedge clk);
        kif.genk = 1'b0; kif.key_in = K2;
        chk("cap_rk0", 4'd0, K1, 1'b1, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            if (j == 4) kif.genk = 1'b1;
            @(negedge clk);
            kif.genk = 1'b0;
            if (j == 1)       chk("rk1_lat", 4'd1, RK1, 1'b1, 1'b0);
            else if (j == 2)  chk("rk2_lat", 4'd2, RK2, 1'b1, 1'b0);
            else if (j == 10) chk("rk10_ready", 4'd10, RK10, 1'b0, 1'b1);
            else              chk("busy_window", 4'd0, K1, 1'b1, 1'b0);
        end
        chk("rk1_done", 4'd1, RK1, 1'b0, 1'b1);
        chk("rk0_kept", 4'd0, K1, 1'b0, 1'b1);
        for (int i = 11; i <= 15; i++) chk("oob_zero", 4'(i), '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ready_hold", 4'd10, RK10, 1'b0, 1'b1);

        // restart from DONE with the all-zero key
        kif.key_in = '0; kif.genk = 1'b1;
        @(negedge clk);
        kif.genk = 1'b0;
        chk("z_cap", 4'd0, '0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
`ifdef KEYEXP_ZEROIZE_EN
        chk("z_stale_rk10", 4'd10, '0, 1'b1, 1'b0);
`else
        chk("z_stale_rk10", 4'd10, RK10, 1'b1, 1'b0);
`endif
        repeat (6) @(negedge clk);
        chk("z_busy_e9", 4'd0, '0, 1'b1, 1'b0);
        @(negedge clk);
        chk("z_rk1", 4'd1, Z1, 1'b0, 1'b1);
        chk("z_rk10", 4'd10, Z10, 1'b0, 1'b1);

        // reset in the middle of an expansion
        @(negedge clk);
        kif.key_in = K1; kif.genk = 1'b1;
        @(negedge clk);
        kif.genk = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) chk("mid_rst", 4'(i), '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_rk0", 4'd0, '0, 1'b0, 1'b0);
        chk("post_rst_rk10", 4'd10, '0, 1'b0, 1'b0);

        // fresh genk after reset runs to completion again
        kif.key_in = K1; kif.genk = 1'b1;
        @(negedge clk);
        kif.genk = 1'b0;
        repeat (10) @(negedge clk);
        chk("again_rk10", 4'd10, RK10, 1'b0, 1'b1);

        #5;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
